// File: rtl/ram_dma_pkg.sv
// Shared types for the RAM DMA engine: FSM state encoding, transfer mode
// encoding and small state-decoding helpers used by the top module.
package ram_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FILL = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } mode_e;

  // True for every state that owns the RAM bus (cs high).
  function automatic logic is_access(input state_e s);
    return (s == S_RD) || (s == S_WR) || (s == S_FILL);
  endfunction

  // True for the states that write the RAM (rw low).
  function automatic logic is_write(input state_e s);
    return (s == S_WR) || (s == S_FILL);
  endfunction

endpackage

// File: rtl/ram_dma.sv
// RAM DMA engine: byte-wise COPY (read src+i, write dst+i) or FILL
// (write fill_value to dst+i) over a single-port RAM with a registered
// read port. Addresses wrap modulo 2^A. cs/rw/addr/busy/done are
// registered from the next state; wdata is a combinational pass-through
// of rdata during WR so the read byte lands in the same cycle.
// Optional feature: define RAM_DMA_CHECKSUM_EN to enable the running
// modulo-2^D sum of written bytes on the checksum output.
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int A = 10,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [A-1:0] src_addr,
  input  logic [A-1:0] dst_addr,
  input  logic [A:0]   len,
  input  logic [D-1:0] fill_value,
  output logic         busy,
  output logic         done,
  output logic         cs,
  output logic         rw,
  output logic [A-1:0] addr,
  output logic [D-1:0] wdata,
  input  logic [D-1:0] rdata,
  output logic [D-1:0] checksum
);

  state_e       state_r;
  state_e       state_nx_s;
  logic [A:0]   i_r;
  logic [A:0]   i_nx_s;
  logic         accept_s;

  mode_e        mode_r;
  logic [A-1:0] src_r;
  logic [A-1:0] dst_r;
  logic [A:0]   len_r;
  logic [D-1:0] fill_r;

  logic [A-1:0] src_nx_s;
  logic [A-1:0] dst_nx_s;
  logic [A-1:0] addr_nx_s;

  logic         busy_r;
  logic         done_r;
  logic         cs_r;
  logic         rw_r;
  logic [A-1:0] addr_r;
  logic [D-1:0] wdata_s;

  // Next-state and byte-index logic; start is only looked at in IDLE.
  always_comb begin
    state_nx_s = state_r;
    i_nx_s     = i_r;
    accept_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          i_nx_s   = '0;
          if (len == '0) begin
            state_nx_s = S_FIN;
          end else if (mode_e'(mode) == MODE_FILL) begin
            state_nx_s = S_FILL;
          end else begin
            state_nx_s = S_RD;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_RD: begin
        state_nx_s = S_WR;
      end
      S_WR: begin
        i_nx_s = i_r + {{A{1'b0}}, 1'b1};
        if (i_nx_s < len_r) begin
          state_nx_s = S_RD;
        end else begin
          state_nx_s = S_FIN;
        end
      end
      S_FILL: begin
        i_nx_s = i_r + {{A{1'b0}}, 1'b1};
        if (i_r == (len_r - {{A{1'b0}}, 1'b1})) begin
          state_nx_s = S_FIN;
        end else begin
          state_nx_s = S_FILL;
        end
      end
      S_FIN: begin
        state_nx_s = S_IDLE;
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // Address for the next cycle; uses the incoming bases on the accept cycle.
  always_comb begin
    src_nx_s = accept_s ? src_addr : src_r;
    dst_nx_s = accept_s ? dst_addr : dst_r;
    case (state_nx_s)
      S_RD:    addr_nx_s = src_nx_s + i_nx_s[A-1:0];
      S_WR:    addr_nx_s = dst_nx_s + i_nx_s[A-1:0];
      S_FILL:  addr_nx_s = dst_nx_s + i_nx_s[A-1:0];
      default: addr_nx_s = '0;
    endcase
  end

  // State, index, latched parameters and registered RAM/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      i_r     <= '0;
      mode_r  <= MODE_COPY;
      src_r   <= '0;
      dst_r   <= '0;
      len_r   <= '0;
      fill_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cs_r    <= 1'b0;
      rw_r    <= 1'b1;
      addr_r  <= '0;
    end else begin
      state_r <= state_nx_s;
      i_r     <= i_nx_s;
      if (accept_s) begin
        mode_r <= mode_e'(mode);
        src_r  <= src_addr;
        dst_r  <= dst_addr;
        len_r  <= len;
        fill_r <= fill_value;
      end
      busy_r <= is_access(state_nx_s);
      done_r <= (state_nx_s == S_FIN);
      cs_r   <= is_access(state_nx_s);
      rw_r   <= !is_write(state_nx_s);
      addr_r <= addr_nx_s;
    end
  end

  // Write data: read byte passes straight through in WR, fill byte in FILL.
  always_comb begin
    case (state_r)
      S_WR:    wdata_s = rdata;
      S_FILL:  wdata_s = fill_r;
      default: wdata_s = '0;
    endcase
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign cs    = cs_r;
  assign rw    = rw_r;
  assign addr  = addr_r;
  assign wdata = wdata_s;

`ifdef RAM_DMA_CHECKSUM_EN
  logic [D-1:0] sum_r;

  // Running sum of written bytes; cleared when a new transfer is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= '0;
    end else if (accept_s) begin
      sum_r <= '0;
    end else if (is_write(state_r)) begin
      sum_r <= sum_r + wdata_s;
    end else begin
      sum_r <= sum_r;
    end
  end

  assign checksum = sum_r;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/ram_dma.md
RAM_DMA -- requirements
Module: ram_dma

Interface
REQ-001 The module SHALL have parameter A, default 10, meaning the RAM address width in bits.
REQ-002 The module SHALL have parameter D, default 8, meaning the RAM data width in bits.
REQ-003 clk  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-004 rst_n  input  1  reset; reset is asynchronous and active-low.
REQ-005 start  input  1  request a transfer; sampled only in IDLE.
REQ-006 mode  input  1  transfer type: 0 = COPY, 1 = FILL; latched at start.
REQ-007 src_addr  input  A  COPY source base address; latched at start.
REQ-008 dst_addr  input  A  destination base address; latched at start.
REQ-009 len  input  A+1  byte count, 0..2^A; latched at start.
REQ-010 fill_value  input  D  FILL data; latched at start.
REQ-011 busy  output  1  high from the cycle after start is accepted until done.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 cs  output  1  RAM chip select.
REQ-014 rw  output  1  RAM direction: 1 = read, 0 = write.
REQ-015 addr  output  A  RAM address.
REQ-016 wdata  output  D  write data, connected to the RAM data_in.
REQ-017 rdata  input  D  read data, connected to the RAM registered data_out; valid the cycle after a read access.
REQ-018 checksum  output  D  running modulo-2^D sum of written bytes (see Configuration).

Function
REQ-019 The FSM SHALL have the states IDLE, RD, WR, FILL and FIN.
REQ-020 In IDLE, start=1 with len!=0 SHALL latch all inputs, clear the byte index i, and enter RD (COPY) or FILL (FILL).
REQ-021 In IDLE, start=1 with len==0 SHALL enter FIN without any RAM access.
REQ-022 RD SHALL drive cs=1, rw=1 and addr=src+i for exactly one cycle, then enter WR.
REQ-023 WR SHALL drive cs=1, rw=0, addr=dst+i and wdata=rdata (combinational pass-through) for one cycle, then increment i.
REQ-024 After WR, the FSM SHALL enter RD if i<len, else FIN.
REQ-025 FILL SHALL drive cs=1, rw=0, addr=dst+i and wdata=fill_value each cycle, incrementing i, and SHALL enter FIN after the access with i=len-1.
REQ-026 FIN SHALL assert done=1 for one cycle with busy=0 and cs=0, then enter IDLE.
REQ-027 Cycle counts: COPY SHALL take 2*len access cycles; FILL SHALL take len access cycles; each is followed by 1 FIN cycle.
REQ-028 Address arithmetic SHALL wrap modulo 2^A (e.g. src=0x3FF, i=1 gives addr 0x000 for A=10).
REQ-029 Copies SHALL proceed in ascending address order, byte by byte; overlapping regions with dst>src SHALL propagate source bytes forward, and this is the defined behaviour.
REQ-030 start asserted while busy SHALL be ignored and SHALL NOT alter the latched parameters.
REQ-031 Outside RD/WR/FILL, the outputs SHALL be cs=0, rw=1, addr=0 and wdata=0.

Reset
REQ-032 While rst_n=0, the block SHALL hold state IDLE, i=0, busy=0, done=0, cs=0, rw=1, addr=0, wdata=0 and checksum=0.
REQ-033 Reset asserted mid-transfer SHALL deassert cs immediately, SHALL abandon the transfer with no done pulse, and SHALL leave already-written bytes untouched.

Configuration
REQ-034 With RAM_DMA_CHECKSUM_EN defined, checksum SHALL clear on start acceptance and SHALL accumulate wdata on every write cycle; it SHALL hold its value after done until the next start.
REQ-035 Without RAM_DMA_CHECKSUM_EN, checksum SHALL be constant 0, and no accumulator logic SHALL be present.

Structure
REQ-036 Package ram_dma_pkg SHALL hold the state enum (IDLE, RD, WR, FILL, FIN) and the mode enum (COPY=0, FILL=1).
REQ-037 The block SHALL be a single module with no sub-module; the bench SHALL instantiate the existing RAM model as the responder.

Verification
REQ-038 RAM preloaded mem[i]=i; COPY src=0x010, dst=0x100, len=4 -> mem[0x100..0x103]=10,11,12,13; done exactly 9 cycles after the start edge; checksum=0x46 when enabled.
REQ-039 FILL dst=0x3FE, len=4, fill_value=0xA5 -> 0x3FE, 0x3FF, 0x000 and 0x001 hold 0xA5; mem[0x002] is unchanged; done is 5 cycles after start.
REQ-040 len=0 -> cs stays 0 throughout; done pulses the cycle after start; busy is never high.
REQ-041 start re-pulsed with different parameters during a len=8 COPY -> the original transfer completes unchanged with a single done pulse.
REQ-042 rst_n pulled low during the 3rd WR of a len=6 COPY -> cs=0 within the same cycle; exactly 2 bytes written (3rd write not committed); no done; a fresh transfer after reset succeeds.
